// File: rtl/i2c_reg_reader.sv
// I2C master that reads NUM_BYTES bytes from register reg_addr of target DEV_ADDR.
// Sequence: START, addr+W, reg pointer, repeated START, addr+R, reads, STOP.
module i2c_reg_reader #(
    parameter int unsigned CLK_DIV   = 125,
    parameter logic [6:0]  DEV_ADDR  = 7'h48,
    parameter int unsigned NUM_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             reg_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err,
    output logic [8*NUM_BYTES-1:0] rd_data,
    output logic                   scl,
    inout  wire                    sda,
    output logic [3:0]             state_info
);

    localparam int unsigned CntW  = $clog2(CLK_DIV);
    localparam int unsigned DataW = 8 * NUM_BYTES;
    localparam logic [2:0]  LastByte = 3'(NUM_BYTES - 1);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StStart  = 4'd1,
        StAddrW  = 4'd2,
        StAck1   = 4'd3,
        StReg    = 4'd4,
        StAck2   = 4'd5,
        StRstart = 4'd6,
        StAddrR  = 4'd7,
        StAck3   = 4'd8,
        StRead   = 4'd9,
        StMack   = 4'd10,
        StStop   = 4'd11,
        StDone   = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [DataW-1:0]  shift_q, shift_d;
    logic [DataW-1:0]  rd_data_q, rd_data_d;
    logic              ack_err_q, ack_err_d;
    logic              scl_q, scl_d;
    logic              sda_oe_q, sda_oe_d;
    logic              in_txn, tick, sample, bit_end, sda_in, tx_bit;
    logic [7:0]        tx_byte;

    assign sda_in = sda;
    assign in_txn = (state_q != StIdle) && (state_q != StDone);
    assign tick    = in_txn && (cnt_q == CntW'(CLK_DIV - 1));
    assign sample  = tick && (qtr_q == 2'd2);
    assign bit_end = tick && (qtr_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        qtr_d      = '0;
        bit_d      = bit_q;
        byte_d     = byte_q;
        reg_addr_d = reg_addr_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        ack_err_d  = ack_err_q;
        if (in_txn) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
            qtr_d = qtr_q + {1'b0, tick};
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    reg_addr_d = reg_addr;
                    ack_err_d  = 1'b0;
                    bit_d      = '0;
                    byte_d     = '0;
                    state_d    = StStart;
                end
            end
            StStart:  if (bit_end) state_d = StAddrW;
            StRstart: if (bit_end) state_d = StAddrR;
            StAddrW, StReg, StAddrR, StRead: begin
                if (state_q == StRead && sample) shift_d = {shift_q[DataW-2:0], sda_in};
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        unique case (state_q)
                            StAddrW: state_d = StAck1;
                            StReg:   state_d = StAck2;
                            StAddrR: state_d = StAck3;
                            default: state_d = StMack;
                        endcase
                    end
                end
            end
            StAck1, StAck2, StAck3: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (bit_end) begin
                    if (ack_err_q)              state_d = StStop;
                    else if (state_q == StAck1) state_d = StReg;
                    else if (state_q == StAck2) state_d = StRstart;
                    else                        state_d = StRead;
                end
            end
            StMack: begin
                if (bit_end) begin
                    if (byte_q == LastByte) begin
                        state_d = StStop;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = StRead;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StDone;
                    if (!ack_err_q) rd_data_d = shift_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus pins are registered from next-state values so they line up with state_q.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        unique case (state_d)
            StAddrW: tx_byte = {DEV_ADDR, 1'b0};
            StReg:   tx_byte = reg_addr_d;
            default: tx_byte = {DEV_ADDR, 1'b1};
        endcase
        tx_bit = tx_byte[3'd7 - bit_d];
        if (state_d != StIdle && state_d != StDone) begin
            scl_d = qtr_d[1];
            unique case (state_d)
                StStart: begin
                    scl_d    = 1'b1;
                    sda_oe_d = qtr_d[1];
                end
                StRstart:                 sda_oe_d = (qtr_d == 2'd3);
                StStop:                   sda_oe_d = (qtr_d != 2'd3);
                StAddrW, StReg, StAddrR:  sda_oe_d = ~tx_bit;
                StMack:                   sda_oe_d = (byte_d != LastByte);
                default:                  sda_oe_d = 1'b0;
            endcase
            // Hold SDA through the SCL falling quarter so data moves mid-low.
            if (qtr_d == 2'd0 && state_d != StStart) sda_oe_d = sda_oe_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            reg_addr_q <= '0;
            shift_q    <= '0;
            rd_data_q  <= '0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            reg_addr_q <= reg_addr_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign scl        = scl_q;
    assign busy       = in_txn;
    assign done       = (state_q == StDone);
    assign ack_err    = ack_err_q;
    assign rd_data    = rd_data_q;
    assign state_info = state_q;

endmodule

// File: doc/i2c_reg_reader.md
I2C_REG_READER -- requirements
Module: i2c_reg_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, system clocks per SCL quarter-period (minimum 2).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h48, 7-bit target address.
REQ-003 SHALL have parameter NUM_BYTES, default 2, bytes read per transaction (range 1..8).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a transaction.
REQ-007 reg_addr  input  8  register pointer, captured when start is accepted.
REQ-008 busy  output  1  transaction in progress.
REQ-009 done  output  1  one-cycle pulse at transaction end, success or error.
REQ-010 ack_err  output  1  sticky; last transaction saw a NACK from the target.
REQ-011 rd_data  output  8*NUM_BYTES  read bytes; first byte received in the MSB byte lane.
REQ-012 scl  output  1  push-pull I2C clock; idle high.
REQ-013 sda  inout  1  open-drain: driven 0 or high-Z, never driven 1.
REQ-014 state_info  output  4  current FSM state code, for seven-segment debug.

Function
REQ-015 Quarter-tick counter SHALL pulse every CLK_DIV clocks while busy; one bit-time = 4 ticks, SCL low for ticks 0-1 and high for ticks 2-3.
REQ-016 SDA SHALL change only during SCL-low ticks; input SHALL be sampled at the start of tick 3 (SCL mid-high).
REQ-017 FSM states and codes: IDLE=0, START=1, ADDR_W=2, ACK1=3, REG=4, ACK2=5, RSTART=6, ADDR_R=7, ACK3=8, READ=9, MACK=10, STOP=11, DONE=12.
REQ-018 In IDLE with start=1 the block SHALL capture reg_addr, clear ack_err, and raise busy on the next cycle.
REQ-019 start while busy SHALL be ignored and SHALL not alter the transaction in progress.
REQ-020 Sequence: START, {DEV_ADDR,0} MSB first, target ACK, reg_addr, target ACK, repeated START, {DEV_ADDR,1}, target ACK, then NUM_BYTES reads.
REQ-021 After each read byte the master SHALL drive ACK (SDA low), except after the last byte, where it SHALL send NACK (released), followed by STOP.
REQ-022 START/RSTART: SDA falls while SCL high; STOP: SDA rises while SCL high; each condition occupies one bit-time.
REQ-023 A successful transaction SHALL take (30 + 9*NUM_BYTES) bit-times from busy rising to STOP completion.
REQ-024 A NACK (SDA sampled 1) in any ACK state SHALL set ack_err, skip to STOP, and leave rd_data unchanged.
REQ-025 rd_data SHALL update atomically in the cycle STOP completes on success, never with partial bytes.
REQ-026 DONE SHALL last one cycle: done=1 and busy=0 in that cycle, then return to IDLE.
REQ-027 The target SHALL not stretch the clock; SCL is not monitored.

Reset
REQ-028 With reset=0 at a clk edge: state IDLE, scl=1, sda released, busy=0, done=0, ack_err=0, rd_data=0, state_info=0, tick counter=0.
REQ-029 Reset mid-transaction SHALL abort immediately, release SDA, and drive SCL high with no STOP generated.

Verification (CLK_DIV=4, DEV_ADDR=7'h48, NUM_BYTES=2, slave model on sda with pull-up)
REQ-030 Slave ACKs all and returns 8'hA5, 8'h3C for reg_addr=8'h10 -> bus shows 0x90, 0x10, 0x91; rd_data=16'hA53C; done pulses once; ack_err=0; busy high for exactly 48*16 clocks.
REQ-031 Slave NACKs the address byte -> ack_err=1, STOP follows within 2 bit-times, rd_data keeps its previous value, done pulses once.
REQ-032 Pulse start again three times while busy -> exactly one transaction on the bus, one done pulse.
REQ-033 Assert reset during the READ state -> next cycle: busy=0, scl=1, sda high-Z, state_info=0; a new start afterwards completes normally.
REQ-034 Protocol checker over the whole run -> SDA never driven 1, SDA transitions during SCL high only at START/RSTART/STOP, master NACK on the final byte only.
REQ-035 Back-to-back: start asserted in the cycle after done -> accepted, second transaction runs with the newly captured reg_addr=8'h22.
